operand_issue: RTL
==================

OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32 from core_pkg, as the operand, PC and immediate width.
REQ-002 The block SHALL take parameter REG_ADDR_WIDTH, default 5 from core_pkg, as the register address width.
REQ-003 The block SHALL take parameter CNT_WIDTH, default 16, as the stall counter width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 id_valid_i  in  1  decoded instruction present in ID.
REQ-007 id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  REG_ADDR_WIDTH each  ID source and destination addresses.
REQ-008 id_reg_write_i, id_mem_read_i  in  1 each  ID control bits.
REQ-009 id_pc_i, id_imm_i  in  DATA_WIDTH each  ID PC and immediate.
REQ-010 rf_rd_data1_i, rf_rd_data2_i  in  DATA_WIDTH each  register-file read data for rs1/rs2.
REQ-011 wb_reg_write_i  in  1; wb_wr_addr_i  in  REG_ADDR_WIDTH; wb_wr_data_i  in  DATA_WIDTH  the same-cycle writeback port.
REQ-012 ex_ready_i  in  1  EX accepts the current EX slot this cycle.
REQ-013 flush_i  in  1  synchronous kill of EX slot (branch/jump redirect).
REQ-014 id_stall_o  out  1  freeze PC and IF/ID this cycle.
REQ-015 ex_valid_o  out  1  EX slot holds a real instruction.
REQ-016 ex_rs1_data_o, ex_rs2_data_o, ex_pc_o, ex_imm_o  out  DATA_WIDTH each  registered operands, PC and immediate.
REQ-017 ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  REG_ADDR_WIDTH each; ex_reg_write_o, ex_mem_read_o  out  1 each  registered fields.
REQ-018 lu_stall_cnt_o  out  CNT_WIDTH  saturating load-use stall cycle count.

Function
REQ-019 Bypass: for rsN (N=1,2), the selected operand SHALL be wb_wr_data_i when wb_reg_write_i=1, wb_wr_addr_i=id_rsN_addr_i and the address is nonzero; otherwise it SHALL be rf_rd_data{N}_i.
REQ-020 rsN address 0 SHALL always yield operand 0, regardless of bypass.
REQ-021 load_use SHALL be 1 iff id_valid_i, ex_valid_o, ex_mem_read_o, ex_rd_addr_o!=0 and ex_rd_addr_o equals id_rs1_addr_i or id_rs2_addr_i.
REQ-022 hold SHALL be 1 iff ex_valid_o=1 and ex_ready_i=0.
REQ-023 id_stall_o SHALL be (load_use OR hold) AND NOT flush_i; it is combinational.
REQ-024 Priority at each edge, highest first: flush, hold, load_use, issue.
REQ-025 flush: ex_valid_o<=0 and the other EX fields SHALL be don't-care.
REQ-026 hold: all EX fields SHALL keep their value, except the refresh in REQ-027.
REQ-027 Hold refresh: if wb_reg_write_i=1 and wb_wr_addr_i equals a nonzero ex_rsN_addr_o, ex_rsN_data_o<=wb_wr_data_i; this applies to both operands independently.
REQ-028 load_use (no hold): ex_valid_o<=0 to insert a bubble; the ID instruction SHALL be re-presented next cycle.
REQ-029 issue: ex_valid_o<=id_valid_i and all EX fields SHALL capture the ID fields, with operands per REQ-019/020; latency is 1 cycle ID to EX.
REQ-030 When ex_valid_o=0, ex_ready_i SHALL be ignored.
REQ-031 lu_stall_cnt_o SHALL increment by 1 on each edge where load_use=1, hold=0 and flush_i=0; it SHALL saturate at all-ones and never wrap.

Reset
REQ-032 While rst=1: ex_valid_o=0; all EX data, address and control outputs=0; lu_stall_cnt_o=0; id_stall_o is combinational with ex_valid_o=0 and evaluates to 0.
REQ-033 Reset asserted mid-hold or mid-stall SHALL discard the EX slot; the first edge after rst deasserts SHALL perform a normal issue.

Verification
REQ-034 rf_rd_data1_i=0x11, wb write x5=0xAB same cycle, id_rs1_addr_i=5 -> next cycle ex_rs1_data_o=0xAB, ex_valid_o=1.
REQ-035 EX holds lw x7 (ex_mem_read_o=1), ID add with rs2=7 -> id_stall_o=1 one cycle, ex_valid_o=0 next cycle, lu_stall_cnt_o=1; add then issues.
REQ-036 ex_valid_o=1, ex_rs1_addr_o=3, ex_ready_i=0 for 3 cycles, wb writes x3=0x55 in cycle 2 -> id_stall_o=1 all 3 cycles, ex_rs1_data_o=0x55 from cycle 3, other fields unchanged.
REQ-037 flush_i=1 together with hold and load_use -> id_stall_o=0, ex_valid_o=0 next cycle, counter unchanged.
REQ-038 id_rs1_addr_i=0 with wb write to x0=0xFF -> ex_rs1_data_o=0; CNT_WIDTH=2 with 5 load-use stalls -> lu_stall_cnt_o=3.
REQ-039 rst pulse while ex_valid_o=1 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_issue.sv
// operand_issue: ID->EX operand register with writeback bypass, load-use/hold stalls,
// flush kill and a saturating load-use stall counter.
module operand_issue #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
    input  logic                      id_reg_write_i,
    input  logic                      id_mem_read_i,
    input  logic [DATA_WIDTH-1:0]     id_pc_i,
    input  logic [DATA_WIDTH-1:0]     id_imm_i,
    input  logic [DATA_WIDTH-1:0]     rf_rd_data1_i,
    input  logic [DATA_WIDTH-1:0]     rf_rd_data2_i,
    input  logic                      wb_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_wr_data_i,
    input  logic                      ex_ready_i,
    input  logic                      flush_i,
    output logic                      id_stall_o,
    output logic                      ex_valid_o,
    output logic [DATA_WIDTH-1:0]     ex_rs1_data_o,
    output logic [DATA_WIDTH-1:0]     ex_rs2_data_o,
    output logic [DATA_WIDTH-1:0]     ex_pc_o,
    output logic [DATA_WIDTH-1:0]     ex_imm_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
    output logic                      ex_reg_write_o,
    output logic                      ex_mem_read_o,
    output logic [CNT_WIDTH-1:0]      lu_stall_cnt_o
);
    logic [DATA_WIDTH-1:0] op1, op2;
    logic load_use, hold;

    always_comb begin
        op1 = (id_rs1_addr_i == '0) ? '0 :
              (wb_reg_write_i && wb_wr_addr_i == id_rs1_addr_i) ? wb_wr_data_i : rf_rd_data1_i;
        op2 = (id_rs2_addr_i == '0) ? '0 :
              (wb_reg_write_i && wb_wr_addr_i == id_rs2_addr_i) ? wb_wr_data_i : rf_rd_data2_i;
        load_use = id_valid_i && ex_valid_o && ex_mem_read_o && ex_rd_addr_o != '0 &&
                   (ex_rd_addr_o == id_rs1_addr_i || ex_rd_addr_o == id_rs2_addr_i);
        hold = ex_valid_o && !ex_ready_i;
        id_stall_o = (load_use || hold) && !flush_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o     <= 1'b0;
            ex_rs1_data_o  <= '0;
            ex_rs2_data_o  <= '0;
            ex_pc_o        <= '0;
            ex_imm_o       <= '0;
            ex_rs1_addr_o  <= '0;
            ex_rs2_addr_o  <= '0;
            ex_rd_addr_o   <= '0;
            ex_reg_write_o <= 1'b0;
            ex_mem_read_o  <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (hold) begin
            // a held instruction must not miss a writeback that lands while it waits
            if (wb_reg_write_i && ex_rs1_addr_o != '0 && wb_wr_addr_i == ex_rs1_addr_o)
                ex_rs1_data_o <= wb_wr_data_i;
            if (wb_reg_write_i && ex_rs2_addr_o != '0 && wb_wr_addr_i == ex_rs2_addr_o)
                ex_rs2_data_o <= wb_wr_data_i;
        end else if (load_use) begin
            ex_valid_o <= 1'b0;
        end else begin
            ex_valid_o     <= id_valid_i;
            ex_rs1_data_o  <= op1;
            ex_rs2_data_o  <= op2;
            ex_pc_o        <= id_pc_i;
            ex_imm_o       <= id_imm_i;
            ex_rs1_addr_o  <= id_rs1_addr_i;
            ex_rs2_addr_o  <= id_rs2_addr_i;
            ex_rd_addr_o   <= id_rd_addr_i;
            ex_reg_write_o <= id_reg_write_i;
            ex_mem_read_o  <= id_mem_read_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lu_stall_cnt_o <= '0;
        else if (load_use && !hold && !flush_i && lu_stall_cnt_o != '1)
            lu_stall_cnt_o <= lu_stall_cnt_o + 1'b1;
    end
endmodule
